// File: rtl/vent_motor_sequencer_if.sv
// Control/status bundle between the gas-leak logic, limit switches and the vent motor sequencer.
// slave = sequencer side, master = the environment driving alarm/limits and reading move/status.
interface vent_motor_sequencer_if;
    logic       ena;
    logic       gas_alarm;
    logic       lim_open;
    logic       lim_closed;
    logic       clear_fault;
    logic [1:0] move;
    logic       busy;
    logic       fault;
    logic [1:0] pos_state;

    modport slave (
        input  ena, gas_alarm, lim_open, lim_closed, clear_fault,
        output move, busy, fault, pos_state
    );

    modport master (
        output ena, gas_alarm, lim_open, lim_closed, clear_fault,
        input  move, busy, fault, pos_state
    );
endinterface

// File: rtl/vent_motor_sequencer.sv
// Vent motor sequencer: alarm -> target position, dead-time before every start, limit stop, fault latch.
// All outputs registered, one cycle after the sampled inputs; no backpressure, inputs are sampled every cycle.
module vent_motor_sequencer #(
    parameter int DEAD_CYCLES    = 50_000,
    parameter int TIMEOUT_CYCLES = 250_000_000,
    parameter int CNT_W          = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vent_motor_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, DEAD, OPENING, CLOSING, FAULT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEAD_LAST    = (DEAD_CYCLES    == 0) ? '0 : CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             dir_q, dir_d;          // 1 = open, 0 = close
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_clr;
    logic [1:0]       pos_q, pos_d;
    logic [1:0]       move_q;
    logic             busy_q, fault_q;
    logic             both, tgt_open, moving;

    assign both     = bus.lim_open & bus.lim_closed;
    assign tgt_open = bus.gas_alarm;
    assign moving   = (state_q == OPENING) || (state_q == CLOSING);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_clr = 1'b0;
        if (state_q == FAULT) begin
            if (bus.clear_fault) state_d = IDLE;
        end else if (both) begin
            state_d = FAULT;
        end else if (!bus.ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tgt_open && !bus.lim_open) begin
                        state_d = DEAD; dir_d = 1'b1; cnt_clr = 1'b1;
                    end else if (!tgt_open && !bus.lim_closed) begin
                        state_d = DEAD; dir_d = 1'b0; cnt_clr = 1'b1;
                    end
                end
                DEAD: begin
                    // A target change restarts the full dead-time in the new direction.
                    if (tgt_open != dir_q) begin
                        dir_d = tgt_open; cnt_clr = 1'b1;
                    end else if (cnt_q >= DEAD_LAST) begin
                        state_d = dir_q ? OPENING : CLOSING; cnt_clr = 1'b1;
                    end
                end
                OPENING: begin
                    if (bus.lim_open)            state_d = IDLE;
                    else if (!tgt_open)          begin state_d = DEAD; dir_d = 1'b0; cnt_clr = 1'b1; end
                    else if (cnt_q >= TIMEOUT_LAST) state_d = FAULT;
                end
                CLOSING: begin
                    if (bus.lim_closed)          state_d = IDLE;
                    else if (tgt_open)           begin state_d = DEAD; dir_d = 1'b1; cnt_clr = 1'b1; end
                    else if (cnt_q >= TIMEOUT_LAST) state_d = FAULT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Inconsistent limits or a fresh fault make the position unknown; otherwise track the switches.
    always_comb begin
        pos_d = pos_q;
        if (both || (state_d == FAULT && state_q != FAULT)) pos_d = 2'b00;
        else if (bus.lim_closed)                             pos_d = 2'b01;
        else if (bus.lim_open)                               pos_d = 2'b10;
        else if (moving)                                     pos_d = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b1;
            cnt_q   <= '0;
            pos_q   <= 2'b00;
            move_q  <= 2'b00;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            if (cnt_clr)               cnt_q <= '0;
            else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
            pos_q   <= pos_d;
            move_q  <= (state_d == OPENING) ? 2'b10 : (state_d == CLOSING) ? 2'b01 : 2'b00;
            busy_q  <= (state_d == DEAD) || (state_d == OPENING) || (state_d == CLOSING);
            fault_q <= (state_d == FAULT);
        end
    end

    assign bus.move      = move_q;
    assign bus.busy      = busy_q;
    assign bus.fault     = fault_q;
    assign bus.pos_state = pos_q;
endmodule

// File: tb/tb_vent_motor_sequencer.sv
// Directed bench for vent_motor_sequencer with DEAD_CYCLES=4, TIMEOUT_CYCLES=20.
// Observed vector o = {move, busy, fault, pos_state}.
module tb_vent_motor_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   mon_viol = 0;
    logic [1:0] last_nz = 2'b00;
    int   zeros = 0;

    vent_motor_sequencer_if bus();

    vent_motor_sequencer #(.DEAD_CYCLES(4), .TIMEOUT_CYCLES(20), .CNT_W(28)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Illegal move code or direct reversal with fewer than 4 stopped cycles
    always @(negedge clk) begin
        if (bus.move == 2'b11) mon_viol++;
        else if (bus.move == 2'b00) zeros++;
        else begin
            if (last_nz != 2'b00 && bus.move != last_nz && zeros < 4) mon_viol++;
            last_nz = bus.move;
            zeros = 0;
        end
    end

    function automatic logic [5:0] obs();
        return {bus.move, bus.busy, bus.fault, bus.pos_state};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.ena = 1'b0; bus.gas_alarm = 1'b0;
        bus.lim_open = 1'b0; bus.lim_closed = 1'b0; bus.clear_fault = 1'b0;
        tick(); tick();
        checks++; if (obs() !== 6'b00_0_0_00) begin errors++; $display("FAIL reset_values: got %b want %b", obs(), 6'b00_0_0_00); end
    endtask

    task automatic test_open();
        rst_n = 1'b1; bus.ena = 1'b1; bus.gas_alarm = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (obs() !== 6'b00_1_0_00) begin errors++; $display("FAIL open_dead[%0d]: got %b want %b", i, obs(), 6'b00_1_0_00); end
        end
        tick();
        checks++; if (obs() !== 6'b10_1_0_00) begin errors++; $display("FAIL open_start: got %b want %b", obs(), 6'b10_1_0_00); end
        bus.lim_open = 1'b1;
        tick();
        checks++; if (obs() !== 6'b00_0_0_10) begin errors++; $display("FAIL open_limit: got %b want %b", obs(), 6'b00_0_0_10); end
        tick();
        checks++; if (obs() !== 6'b00_0_0_10) begin errors++; $display("FAIL open_hold: got %b want %b", obs(), 6'b00_0_0_10); end
    endtask

    task automatic test_reverse();
        bus.lim_open = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (obs() !== 6'b00_1_0_10) begin errors++; $display("FAIL rev_dead1[%0d]: got %b want %b", i, obs(), 6'b00_1_0_10); end
        end
        tick();
        checks++; if (obs() !== 6'b10_1_0_10) begin errors++; $display("FAIL rev_opening: got %b want %b", obs(), 6'b10_1_0_10); end
        tick();
        checks++; if (obs() !== 6'b10_1_0_00) begin errors++; $display("FAIL rev_left_limit: got %b want %b", obs(), 6'b10_1_0_00); end
        bus.gas_alarm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (obs() !== 6'b00_1_0_00) begin errors++; $display("FAIL rev_dead2[%0d]: got %b want %b", i, obs(), 6'b00_1_0_00); end
        end
        tick();
        checks++; if (obs() !== 6'b01_1_0_00) begin errors++; $display("FAIL rev_closing: got %b want %b", obs(), 6'b01_1_0_00); end
        bus.lim_closed = 1'b1;
        tick();
        checks++; if (obs() !== 6'b00_0_0_01) begin errors++; $display("FAIL rev_closed: got %b want %b", obs(), 6'b00_0_0_01); end
    endtask

    task automatic test_timeout();
        int n;
        bus.gas_alarm = 1'b1; bus.lim_closed = 1'b0;
        repeat (4) tick();
        checks++; if (obs() !== 6'b00_1_0_01) begin errors++; $display("FAIL to_dead: got %b want %b", obs(), 6'b00_1_0_01); end
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.move != 2'b10) break;
            n++;
        end
        checks++; if (n !== 20) begin errors++; $display("FAIL to_motion_len: got %0d want %0d", n, 20); end
        checks++; if (obs() !== 6'b00_0_1_00) begin errors++; $display("FAIL to_fault: got %b want %b", obs(), 6'b00_0_1_00); end
        bus.gas_alarm = 1'b0; tick(); bus.gas_alarm = 1'b1; tick(); bus.gas_alarm = 1'b0; tick();
        checks++; if (obs() !== 6'b00_0_1_00) begin errors++; $display("FAIL to_fault_hold: got %b want %b", obs(), 6'b00_0_1_00); end
        bus.gas_alarm = 1'b1; bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        checks++; if (obs() !== 6'b00_0_0_00) begin errors++; $display("FAIL to_clear_idle: got %b want %b", obs(), 6'b00_0_0_00); end
        tick();
        checks++; if (obs() !== 6'b00_1_0_00) begin errors++; $display("FAIL to_clear_dead: got %b want %b", obs(), 6'b00_1_0_00); end
        repeat (3) tick();
        tick();
        checks++; if (obs() !== 6'b10_1_0_00) begin errors++; $display("FAIL to_restart: got %b want %b", obs(), 6'b10_1_0_00); end
    endtask

    task automatic test_both_limits();
        bus.lim_open = 1'b1; bus.lim_closed = 1'b1;
        tick();
        checks++; if (obs() !== 6'b00_0_1_00) begin errors++; $display("FAIL both_moving: got %b want %b", obs(), 6'b00_0_1_00); end
        bus.clear_fault = 1'b1; tick(); bus.clear_fault = 1'b0;
        checks++; if (obs() !== 6'b00_0_0_00) begin errors++; $display("FAIL both_clear: got %b want %b", obs(), 6'b00_0_0_00); end
        tick();
        checks++; if (obs() !== 6'b00_0_1_00) begin errors++; $display("FAIL both_reenter: got %b want %b", obs(), 6'b00_0_1_00); end
        bus.lim_open = 1'b0; bus.lim_closed = 1'b0;
        bus.clear_fault = 1'b1; tick(); bus.clear_fault = 1'b0;
        bus.ena = 1'b0;
        tick();
        checks++; if (obs() !== 6'b00_0_0_00) begin errors++; $display("FAIL both_idle: got %b want %b", obs(), 6'b00_0_0_00); end
        bus.lim_open = 1'b1; bus.lim_closed = 1'b1;
        tick();
        checks++; if (obs() !== 6'b00_0_1_00) begin errors++; $display("FAIL both_in_idle: got %b want %b", obs(), 6'b00_0_1_00); end
        bus.lim_open = 1'b0; bus.lim_closed = 1'b0;
        bus.clear_fault = 1'b1; tick(); bus.clear_fault = 1'b0;
        checks++; if (obs() !== 6'b00_0_0_00) begin errors++; $display("FAIL both_exit: got %b want %b", obs(), 6'b00_0_0_00); end
    endtask

    task automatic test_ena_reset();
        bus.ena = 1'b1; bus.gas_alarm = 1'b0;
        repeat (4) tick();
        tick();
        checks++; if (obs() !== 6'b01_1_0_00) begin errors++; $display("FAIL er_closing: got %b want %b", obs(), 6'b01_1_0_00); end
        tick();
        bus.ena = 1'b0;
        tick();
        checks++; if (obs() !== 6'b00_0_0_00) begin errors++; $display("FAIL er_ena_stop: got %b want %b", obs(), 6'b00_0_0_00); end
        bus.ena = 1'b1; bus.gas_alarm = 1'b1;
        repeat (4) tick();
        tick();
        checks++; if (obs() !== 6'b10_1_0_00) begin errors++; $display("FAIL er_opening: got %b want %b", obs(), 6'b10_1_0_00); end
        rst_n = 1'b0;
        tick();
        checks++; if (obs() !== 6'b00_0_0_00) begin errors++; $display("FAIL er_reset: got %b want %b", obs(), 6'b00_0_0_00); end
        rst_n = 1'b1;
        tick();
        checks++; if (obs() !== 6'b00_1_0_00) begin errors++; $display("FAIL er_via_dead: got %b want %b", obs(), 6'b00_1_0_00); end
        repeat (3) tick();
        tick();
        checks++; if (obs() !== 6'b10_1_0_00) begin errors++; $display("FAIL er_restart: got %b want %b", obs(), 6'b10_1_0_00); end
    endtask

    task automatic test_hold_open();
        rst_n = 1'b0; bus.ena = 1'b1; bus.gas_alarm = 1'b1; bus.lim_open = 1'b1; bus.lim_closed = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (obs() !== 6'b00_0_0_10) begin errors++; $display("FAIL hold_open[%0d]: got %b want %b", i, obs(), 6'b00_0_0_10); end
        end
    endtask

    task automatic test_dead_restart();
        bus.lim_open = 1'b0;
        tick(); tick();
        bus.gas_alarm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (obs() !== 6'b00_1_0_10) begin errors++; $display("FAIL dr_dead[%0d]: got %b want %b", i, obs(), 6'b00_1_0_10); end
        end
        tick();
        checks++; if (obs() !== 6'b01_1_0_10) begin errors++; $display("FAIL dr_closing: got %b want %b", obs(), 6'b01_1_0_10); end
    endtask

    task automatic test_monitor();
        checks++; if (mon_viol !== 0) begin errors++; $display("FAIL move_sequence: got %0d violations want %0d", mon_viol, 0); end
    endtask

    initial begin
        test_reset();
        test_open();
        test_reverse();
        test_timeout();
        test_both_limits();
        test_ena_reset();
        test_hold_open();
        test_dead_restart();
        test_monitor();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
